// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants and state type for the text console
package text_console_pkg;

  // Register select values on ADDR
  localparam logic [1:0] REG_CHAR   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_ATTR   = 2'd2;
  localparam logic [1:0] REG_CURSOR = 2'd3;

  // Control codes recognised in the character stream
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;

  // Bit positions inside a REG_CTRL write
  localparam int CTRL_CLEAR   = 0;
  localparam int CTRL_SCROLL  = 1;
  localparam int CTRL_OVR_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CLEAR       = 2'd1,
    ST_SCROLL_FILL = 2'd2
  } state_t;

endpackage

// File: rtl/text_console_ram.sv
// rtl/text_console_ram.sv - simple dual-port cell buffer with registered read
module text_console_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Write port; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to the same cell yields the old word
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console.sv
// rtl/text_console.sv - text-mode console engine: cursor, control codes, scroll ring, fills
module text_console
  import text_console_pkg::*;
#(
  parameter int                COLS         = 80,
  parameter int                ROWS         = 30,
  parameter int                CHAR_W       = 8,
  parameter int                ATTR_W       = 6,
  parameter logic [ATTR_W-1:0] DEFAULT_ATTR = 6'b010_000
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     WR_STB,
  input  logic [1:0]               ADDR,
  input  logic [7:0]               DATA,
  output logic                     BUSY,
  output logic                     OVERRUN,
  output logic [$clog2(COLS)-1:0]  CURSOR_COL,
  output logic [$clog2(ROWS)-1:0]  CURSOR_ROW,
  input  logic [$clog2(COLS)-1:0]  RD_COL,
  input  logic [$clog2(ROWS)-1:0]  RD_ROW,
  output logic [CHAR_W-1:0]        RD_CHAR,
  output logic [ATTR_W-1:0]        RD_ATTR
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int DW = CHAR_W + ATTR_W;

  state_t            state, state_n;
  logic [CW-1:0]     col, col_n;
  logic [RW-1:0]     row, row_n;
  logic [RW-1:0]     top, top_n;
  logic [ATTR_W-1:0] attr, attr_n;
  logic              overrun, overrun_n;
  logic [AW-1:0]     cnt, cnt_n;
  logic [AW-1:0]     base, base_n;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [AW-1:0]     raddr;
  logic [DW-1:0]     rdata;
  logic              rd_in, rd_ok;

  logic              adv_line;
  logic              adv_top;

  // Logical row plus ring offset, folded once (both operands are below ROWS)
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                               input logic [RW-1:0] t,
                                               input logic [CW-1:0] c);
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return AW'(s) * AW'(COLS) + AW'(c);
  endfunction

  // State and datapath registers; reset lands in CLEAR so the buffer is wiped
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_CLEAR;
      col     <= '0;
      row     <= '0;
      top     <= '0;
      attr    <= DEFAULT_ATTR;
      overrun <= 1'b0;
      cnt     <= '0;
      base    <= '0;
    end else begin
      state   <= state_n;
      col     <= col_n;
      row     <= row_n;
      top     <= top_n;
      attr    <= attr_n;
      overrun <= overrun_n;
      cnt     <= cnt_n;
      base    <= base_n;
    end
  end

  // Next-state: register decode in IDLE, one fill write per cycle otherwise
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    top_n     = top;
    attr_n    = attr;
    overrun_n = overrun;
    cnt_n     = cnt;
    base_n    = base;
    we        = 1'b0;
    waddr     = cnt;
    wdata     = {{CHAR_W{1'b0}}, attr};
    adv_line  = 1'b0;
    adv_top   = 1'b0;

    case (state)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == AW'(N - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_SCROLL_FILL: begin
        we    = 1'b1;
        waddr = base + cnt;
        if (cnt == AW'(COLS - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        if (WR_STB) begin
          case (ADDR)
            REG_CHAR: begin
              case (DATA)
                CC_LF: adv_line = 1'b1;
                CC_CR: col_n = '0;
                CC_BS: if (col != '0) col_n = col - 1'b1;
                default: begin
                  we    = 1'b1;
                  waddr = cell_addr(row, top, col);
                  wdata = {DATA[CHAR_W-1:0], attr};
                  if (col == CW'(COLS - 1)) begin
                    col_n    = '0;
                    adv_line = 1'b1;
                  end else begin
                    col_n = col + 1'b1;
                  end
                end
              endcase
            end
            REG_CTRL: begin
              if (DATA[CTRL_CLEAR]) begin
                col_n   = '0;
                row_n   = '0;
                top_n   = '0;
                cnt_n   = '0;
                state_n = ST_CLEAR;
              end else if (DATA[CTRL_SCROLL]) begin
                adv_top = 1'b1;
              end
              if (DATA[CTRL_OVR_CLR]) overrun_n = 1'b0;
            end
            REG_ATTR: attr_n = DATA[ATTR_W-1:0];
            default: begin
              if (DATA[7])
                row_n = (DATA[6:0] > 7'(ROWS - 1)) ? RW'(ROWS - 1) : RW'(DATA[6:0]);
              else
                col_n = (DATA[6:0] > 7'(COLS - 1)) ? CW'(COLS - 1) : CW'(DATA[6:0]);
            end
          endcase
        end

        if (adv_line) begin
          if (row < RW'(ROWS - 1)) row_n = row + 1'b1;
          else                     adv_top = 1'b1;
        end

        // The old top physical row becomes the new bottom row and is blanked
        if (adv_top) begin
          top_n   = (top == RW'(ROWS - 1)) ? '0 : top + 1'b1;
          base_n  = cell_addr('0, top, '0);
          cnt_n   = '0;
          state_n = ST_SCROLL_FILL;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (WR_STB && (state != ST_IDLE)) overrun_n = 1'b1;
  end

  assign rd_in = ({1'b0, RD_COL} < (CW+1)'(COLS)) && ({1'b0, RD_ROW} < (RW+1)'(ROWS));
  assign raddr = rd_in ? cell_addr(RD_ROW, top, RD_COL) : '0;

  // Remember whether the sampled read address was on screen; masks reset and out-of-range reads
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rd_ok <= 1'b0;
    else          rd_ok <= rd_in;
  end

  text_console_ram #(
    .DEPTH(N),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (CLK),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign RD_CHAR    = rd_ok ? rdata[DW-1:ATTR_W] : '0;
  assign RD_ATTR    = rd_ok ? rdata[ATTR_W-1:0]  : '0;
  assign BUSY       = (state != ST_IDLE);
  assign OVERRUN    = overrun;
  assign CURSOR_COL = col;
  assign CURSOR_ROW = row;

endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - directed self-checking bench for text_console (80x30)
module tb_text_console;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CW   = 7;
  localparam int RW   = 5;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          WR_STB = 1'b0;
  logic [1:0]    ADDR = 2'd0;
  logic [7:0]    DATA = 8'd0;
  logic          BUSY;
  logic          OVERRUN;
  logic [CW-1:0] CURSOR_COL;
  logic [RW-1:0] CURSOR_ROW;
  logic [CW-1:0] RD_COL = '0;
  logic [RW-1:0] RD_ROW = '0;
  logic [7:0]    RD_CHAR;
  logic [5:0]    RD_ATTR;

  int vecs = 0;
  int errs = 0;

  text_console dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .WR_STB    (WR_STB),
    .ADDR      (ADDR),
    .DATA      (DATA),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW),
    .RD_COL    (RD_COL),
    .RD_ROW    (RD_ROW),
    .RD_CHAR   (RD_CHAR),
    .RD_ATTR   (RD_ATTR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ADDR   = a;
    DATA   = d;
    WR_STB = 1'b1;
    tick();
    WR_STB = 1'b0;
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] ch, output logic [5:0] at);
    RD_ROW = 5'(r);
    RD_COL = 7'(c);
    tick();
    ch = RD_CHAR;
    at = RD_ATTR;
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (BUSY && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic scan(input int r0, input int r1, input logic [7:0] ec,
                      input logic [5:0] ea, output int bad);
    logic [7:0] ch;
    logic [5:0] at;
    bad = 0;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rd(r, c, ch, at);
        if (ch !== ec || at !== ea) bad++;
      end
    end
  endtask

  initial begin
    int         n;
    int         bad;
    logic [7:0] ch;
    logic [5:0] at;

    // Reset state
    tick();
    tick();
    chk("rst_busy",    32'(BUSY),       32'd1);
    chk("rst_overrun", 32'(OVERRUN),    32'd0);
    chk("rst_col",     32'(CURSOR_COL), 32'd0);
    chk("rst_row",     32'(CURSOR_ROW), 32'd0);
    chk("rst_rdchar",  32'(RD_CHAR),    32'd0);
    chk("rst_rdattr",  32'(RD_ATTR),    32'd0);

    // Clear after release lasts exactly 80*30 cycles and blanks every cell
    RESET_N = 1'b1;
    wait_idle(3000, n);
    chk("clear_len", 32'(n), 32'd2400);
    scan(0, ROWS - 1, 8'h00, 6'b010_000, bad);
    chk("blank_after_reset", 32'(bad), 32'd0);

    // 'A','B',CR,'C'
    wr(2'd0, 8'h41);
    wr(2'd0, 8'h42);
    wr(2'd0, 8'h0D);
    wr(2'd0, 8'h43);
    rd(0, 0, ch, at);
    chk("cell00_char", 32'(ch), 32'h43);
    chk("cell00_attr", 32'(at), 32'h10);
    rd(0, 1, ch, at);
    chk("cell01_char", 32'(ch), 32'h42);
    chk("abc_col", 32'(CURSOR_COL), 32'd1);
    chk("abc_row", 32'(CURSOR_ROW), 32'd0);

    // New attribute, CR, then a full row of 'X' wraps the cursor
    wr(2'd2, 8'h21);
    wr(2'd0, 8'h0D);
    for (int i = 0; i < COLS; i++) wr(2'd0, 8'h58);
    scan(0, 0, 8'h58, 6'b100_001, bad);
    chk("row0_x", 32'(bad), 32'd0);
    chk("wrap_col", 32'(CURSOR_COL), 32'd0);
    chk("wrap_row", 32'(CURSOR_ROW), 32'd1);

    // Bottom row, 'Z', LF -> scroll by one with an 80-cycle fill
    wr(2'd3, 8'h9D);
    chk("set_row29", 32'(CURSOR_ROW), 32'd29);
    wr(2'd0, 8'h5A);
    wr(2'd0, 8'h0A);
    chk("scroll_busy", 32'(BUSY), 32'd1);
    wait_idle(200, n);
    chk("scroll_len", 32'(n), 32'd80);
    chk("scroll_row", 32'(CURSOR_ROW), 32'd29);
    chk("scroll_col", 32'(CURSOR_COL), 32'd1);
    rd(28, 0, ch, at);
    chk("row28_z", 32'({ch, at}), 32'({8'h5A, 6'b100_001}));
    scan(29, 29, 8'h00, 6'b100_001, bad);
    chk("row29_blank", 32'(bad), 32'd0);
    rd(0, 0, ch, at);
    chk("top_shift", 32'({ch, at}), 32'({8'h00, 6'b010_000}));
    rd(28, 79, ch, at);
    chk("last_col_read", 32'({ch, at}), 32'({8'h00, 6'b010_000}));

    // Cursor-set saturation
    wr(2'd3, 8'h7F);
    chk("col_sat", 32'(CURSOR_COL), 32'd79);
    wr(2'd3, 8'h80);
    chk("row_zero", 32'(CURSOR_ROW), 32'd0);
    wr(2'd3, 8'hFF);
    chk("row_sat", 32'(CURSOR_ROW), 32'd29);

    // Backspace moves left and saturates at column 0
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h08);
    chk("bs_col4", 32'(CURSOR_COL), 32'd4);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h08);
    chk("bs_sat", 32'(CURSOR_COL), 32'd0);

    // Out-of-range reads return zero
    rd(0, 100, ch, at);
    chk("oor_col", 32'({ch, at}), 32'd0);
    rd(30, 0, ch, at);
    chk("oor_row", 32'({ch, at}), 32'd0);

    // Write during CLEAR is dropped and flags OVERRUN
    wr(2'd1, 8'h01);
    chk("clr_busy", 32'(BUSY), 32'd1);
    wr(2'd0, 8'h51);
    chk("ovr_set", 32'(OVERRUN), 32'd1);
    wait_idle(3000, n);
    chk("clr_rest_len", 32'(n), 32'd2399);
    chk("ovr_sticky", 32'(OVERRUN), 32'd1);
    chk("clr_col", 32'(CURSOR_COL), 32'd0);
    chk("clr_row", 32'(CURSOR_ROW), 32'd0);
    rd(0, 0, ch, at);
    chk("clr_cell00", 32'({ch, at}), 32'({8'h00, 6'b100_001}));
    wr(2'd1, 8'h04);
    chk("ovr_clr", 32'(OVERRUN), 32'd0);

    // Reset in the middle of a scroll fill restarts a full clear
    wr(2'd3, 8'h9D);
    wr(2'd0, 8'h4B);
    wr(2'd0, 8'h0A);
    repeat (10) tick();
    chk("mid_fill_busy", 32'(BUSY), 32'd1);
    RESET_N = 1'b0;
    tick();
    chk("rst2_col", 32'(CURSOR_COL), 32'd0);
    chk("rst2_row", 32'(CURSOR_ROW), 32'd0);
    chk("rst2_busy", 32'(BUSY), 32'd1);
    RESET_N = 1'b1;
    wait_idle(3000, n);
    chk("clear2_len", 32'(n), 32'd2400);
    scan(0, ROWS - 1, 8'h00, 6'b010_000, bad);
    chk("blank_after_rst2", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Parametrised text-mode console engine, the successor to the fixed 80x60 character writer.
- Owns a COLS x ROWS character/attribute buffer and a cursor. Accepts byte-wide register writes from the already-synchronised CPU bus strobe.
- Implements control codes, auto-wrap, hardware scroll via a row-offset ring, clear and per-cell colour attributes.
- The pixel pipeline reads cells through a registered, 1-cycle read port; the whole block runs on the pixel clock.

Parameters:
- COLS, 80, characters per row (2..128).
- ROWS, 30, character rows (2..128).
- CHAR_W, 8, bits per character code.
- ATTR_W, 6, attribute bits per cell ({fg[2:0], bg[2:0]}).
- DEFAULT_ATTR, 6'b010_000, attribute after reset (green on black).

Ports:
- CLK  in  1  pixel clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- WR_STB  in  1  one-cycle CPU write strobe, already synchronised to CLK.
- ADDR  in  2  register select.
- DATA  in  8  write data.
- BUSY  out  1  high while a clear or scroll fill runs.
- OVERRUN  out  1  sticky flag: a write arrived while BUSY.
- CURSOR_COL  out  $clog2(COLS)  logical cursor column.
- CURSOR_ROW  out  $clog2(ROWS)  logical cursor row.
- RD_COL  in  $clog2(COLS)  display read column.
- RD_ROW  in  $clog2(ROWS)  display read row (logical, 0 = top of screen).
- RD_CHAR  out  CHAR_W  character at (RD_ROW, RD_COL), 1-cycle latency.
- RD_ATTR  out  ATTR_W  attribute at the same cell, 1-cycle latency.

Behaviour:
- Reset:
  - Cursor goes to 0,0; top-row offset TOP=0; attr=DEFAULT_ATTR; OVERRUN=0; RD_CHAR/RD_ATTR=0.
  - State goes to CLEAR and BUSY=1.
  - Assertion mid-fill restarts the fill from cell 0 after release.
- Physical row is (logical row + TOP) mod ROWS. Cell address is phys_row*COLS + col. No power-of-two assumption.
- States: IDLE, CLEAR, SCROLL_FILL.
- IDLE, WR_STB with ADDR=0 (character), one cycle:
  - 0x0A: newline.
  - 0x0D: col=0.
  - 0x08: col-1, saturating at 0; no erase.
  - Any other byte: write {DATA[CHAR_W-1:0], attr} at the cursor, then col+1. When col==COLS-1, col=0 and newline.
- Newline:
  - If row<ROWS-1: row+1.
  - Else: row stays, TOP=(TOP+1) mod ROWS, enter SCROLL_FILL.
- ADDR=1 (control):
  - bit0 clear: cursor 0,0, TOP=0, enter CLEAR.
  - bit1 scroll: newline logic on TOP only; cursor unchanged.
  - bit2: clear OVERRUN.
  - bit0 and bit1 together: clear wins.
- ADDR=2: attr <= DATA[ATTR_W-1:0]. Affects subsequent writes and fills only.
- ADDR=3 (cursor set):
  - DATA[7]=0: col = min(DATA[6:0], COLS-1).
  - DATA[7]=1: row = min(DATA[6:0], ROWS-1).
- CLEAR: writes {0, attr} to one cell per cycle across all COLS*ROWS cells, then returns to IDLE. BUSY is high exactly COLS*ROWS cycles.
- SCROLL_FILL: writes {0, attr} across the new bottom physical row (COLS cycles), then returns to IDLE.
- WR_STB while BUSY: write is dropped, OVERRUN=1, and the fill continues undisturbed.
- Read port:
  - RD_* are registered: the value is visible the cycle after RD_COL/RD_ROW are presented.
  - Reads see the TOP mapping in effect at sample time.
  - Out-of-range RD_COL/RD_ROW returns 0/0.
  - Same-cycle read/write to one cell returns old data.

Decomposition:
- Package text_console_pkg holds:
  - register address constants REG_CHAR/REG_CTRL/REG_ATTR/REG_CURSOR;
  - control-code constants CC_LF/CC_CR/CC_BS;
  - CTRL bit indices;
  - state enum.
- Sub-module text_console_ram: simple dual-port RAM, COLS*ROWS x (CHAR_W+ATTR_W), one write port and one registered read port, inferable as BRAM.

Test Plan:
- Reset release -> BUSY high for exactly 2400 cycles (80x30); afterwards every cell reads 0x00 with attr 6'b010_000.
- Write 'A','B',0x0D,'C' -> cell(0,0)='C', cell(0,1)='B', cursor 0,1.
- Write ATTR=6'b100_001, then 80 x 'X' -> row 0 fully 'X' with attr 100_001; cursor wraps to col 0, row 1.
- Cursor to row 29, write 'Z', 0x0A -> TOP=1 and BUSY for 80 cycles; logical row 28 reads 'Z'; row 29 reads blank; cursor row stays 29.
- WR_STB during CLEAR -> write ignored and OVERRUN=1; CTRL write 0x04 -> OVERRUN=0.
- Assert RESET_N mid-SCROLL_FILL -> cursor 0,0, TOP=0, full CLEAR restarts and the screen ends blank.
